// File: rtl/shift_pkg.sv
// Shared types and default sizing for the iterative shift unit.
package shift_pkg;

  // Operation encoding as presented on the op port.
  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    PASS = 2'b11
  } shift_op_e;

  // Sequencer states of the iterative shifter.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shifter_state_e;

  localparam int XLEN_DEF = 32;
  localparam int STEP_DEF = 1;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: moves an XLEN value by 0..STEP bits,
// left with zero fill or right with a caller-supplied fill bit.
module shift_step #(
  parameter int XLEN = 32,
  parameter int STEP = 1,
  localparam int KW = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] data,
  input  logic [KW-1:0]   amt,
  input  logic            dir_right,
  input  logic            fill,
  output logic [XLEN-1:0] shifted
);

  logic signed [XLEN:0] ext;

  // Prepending the fill bit lets one arithmetic shift cover both SRL and SRA.
  always_comb begin
    ext     = {fill, data};
    shifted = dir_right ? XLEN'(ext >>> amt) : (data << amt);
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle SLL/SRL/SRA unit with valid/ready on both sides. The
// acceptance edge already performs the first step, so an operation needs
// max(1, ceil(shamt/STEP)) edges before its result is offered.
module iter_shifter
  import shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int STEP = STEP_DEF,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand,
  input  logic [SHW-1:0]  shamt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int KW = $clog2(STEP + 1);
  localparam int CW = (KW > SHW) ? KW : SHW;

  if ((XLEN < 8) || ((XLEN & (XLEN - 1)) != 0)) begin : g_bad_xlen
    $error("iter_shifter: XLEN must be a power of 2 and at least 8");
  end
  if ((STEP < 1) || (STEP > XLEN) || ((STEP & (STEP - 1)) != 0)) begin : g_bad_step
    $error("iter_shifter: STEP must be a power of 2 in 1..XLEN");
  end

  shifter_state_e state;
  shift_op_e      op_q;
  shift_op_e      cur_op;
  logic           sign_q;
  logic           cur_sign;
  logic [SHW-1:0] remaining;
  logic [SHW-1:0] cur_rem;
  logic [SHW-1:0] rem_next;
  logic [XLEN-1:0] cur_data;
  logic [XLEN-1:0] step_out;
  logic [CW-1:0]  rem_ext;
  logic [CW-1:0]  k_ext;
  logic [KW-1:0]  k;
  logic           dir_right;
  logic           fill;

  // In IDLE the step unit works on the incoming request so the acceptance
  // edge counts as the first iteration; afterwards it works on the latched copy.
  always_comb begin
    if (state == IDLE) begin
      cur_data = operand;
      cur_op   = shift_op_e'(op);
      cur_rem  = shamt;
      cur_sign = operand[XLEN-1];
    end else begin
      cur_data = result;
      cur_op   = op_q;
      cur_rem  = remaining;
      cur_sign = sign_q;
    end
    rem_ext   = CW'(cur_rem);
    if (cur_op == PASS) begin
      k_ext = '0;
    end else if (rem_ext >= CW'(STEP)) begin
      k_ext = CW'(STEP);
    end else begin
      k_ext = rem_ext;
    end
    k         = KW'(k_ext);
    rem_next  = SHW'(rem_ext - k_ext);
    dir_right = (cur_op == SRL) || (cur_op == SRA);
    fill      = (cur_op == SRA) && cur_sign;
  end

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .data      (cur_data),
    .amt       (k),
    .dir_right (dir_right),
    .fill      (fill),
    .shifted   (step_out)
  );

  // Sequencer, iteration counter and result register; flush overrides all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      result    <= '0;
      remaining <= '0;
      op_q      <= SLL;
      sign_q    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= cur_op;
            sign_q    <= cur_sign;
            result    <= step_out;
            remaining <= rem_next;
            state     <= ((rem_next == '0) || (cur_op == PASS)) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          result    <= step_out;
          remaining <= rem_next;
          if (rem_next == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: five instances (STEP 1,2,4,8,32) share one request
// stream; a latency/result model checks every instance on every cycle.
module tb_iter_shifter;

  localparam int NI = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand = 32'd0;
  logic [4:0]  shamt = 5'd0;

  logic [NI-1:0] drdy;
  logic [NI-1:0] dval;
  logic [NI-1:0] dbusy;
  logic [31:0]   dres [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = 1 << ((g == 4) ? 5 : g);
    iter_shifter #(.XLEN(32), .STEP(S)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (drdy[g]),
      .op        (op),
      .operand   (operand),
      .shamt     (shamt),
      .out_valid (dval[g]),
      .out_ready (out_ready),
      .result    (dres[g]),
      .busy      (dbusy[g])
    );
  end

  // Model state per instance
  bit          m_pend [NI];
  bit          m_val  [NI];
  int          m_cnt  [NI];
  logic [31:0] m_res  [NI];
  int          acc    [NI];
  int          lat_seen [NI];
  logic [31:0] res_seen [NI];
  bit          prev_v [NI];
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic int stp(int i);
    return 1 << ((i == 4) ? 5 : i);
  endfunction

  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] a, int s);
    case (o)
      2'd0:    return a << s;
      2'd1:    return a >> s;
      2'd2:    return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(logic [1:0] o, int s, int st);
    if (o == 2'd3 || s == 0) return 1;
    return (s + st - 1) / st;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare DUTs against the model, then advance the model over the next edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        m_pend[i] = 0; m_val[i] = 0; m_res[i] = 32'd0;
      end
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("out_valid[%0d]", i), 32'(dval[i]), 32'(m_val[i]));
      chk($sformatf("in_ready[%0d]", i), 32'(drdy[i]), 32'(!(m_pend[i] || m_val[i])));
      chk($sformatf("busy[%0d]", i), 32'(dbusy[i]), 32'(m_pend[i] || m_val[i]));
      if (m_val[i] || !reset_n) chk($sformatf("result[%0d]", i), dres[i], m_res[i]);
      if (dval[i] && !prev_v[i]) begin
        lat_seen[i] = cyc - acc[i] + 1;
        res_seen[i] = dres[i];
      end
      prev_v[i] = dval[i];
    end
    if (reset_n) begin
      for (int i = 0; i < NI; i++) begin
        if (flush) begin
          m_pend[i] = 0; m_val[i] = 0;
        end else if (m_val[i]) begin
          if (out_ready) m_val[i] = 0;
        end else if (m_pend[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin m_pend[i] = 0; m_val[i] = 1; end
        end else if (in_valid) begin
          m_res[i]    = ref_shift(op, operand, int'(shamt));
          m_cnt[i]    = ref_lat(op, int'(shamt), stp(i)) - 1;
          acc[i]      = cyc + 1;
          lat_seen[i] = 0;
          if (m_cnt[i] == 0) m_val[i] = 1; else m_pend[i] = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      if (&drdy) return;
      @(posedge clk); #1;
    end
    n_total++;
    $display("FAIL wait_idle: timed out, in_ready=%b", drdy);
  endtask

  task automatic wait_all_valid();
    for (int n = 0; n < 100; n++) begin
      if (&dval) return;
      @(posedge clk); #1;
    end
    n_total++;
    $display("FAIL wait_valid: timed out, out_valid=%b", dval);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input int s);
    wait_idle();
    op = o; operand = a; shamt = 5'(s); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input int s);
    issue(o, a, s);
    wait_idle();
  endtask

  task automatic lit(input int i, input logic [31:0] r, input int l);
    chk($sformatf("lit_result[%0d]", i), res_seen[i], r);
    chk($sformatf("lit_latency[%0d]", i), 32'(lat_seen[i]), 32'(l));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 0; m_val[i] = 0; m_cnt[i] = 0; m_res[i] = 0;
      acc[i] = 0; lat_seen[i] = 0; res_seen[i] = 0; prev_v[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_result", dres[0], 32'h0);
    chk("reset_in_ready", 32'(drdy), 32'h1F);
    chk("reset_busy", 32'(dbusy), 32'h0);

    // SRL 0x48 by 3
    run_op(2'd1, 32'h0000_0048, 3);
    lit(0, 32'h0000_0009, 3);
    lit(1, 32'h0000_0009, 2);
    lit(4, 32'h0000_0009, 1);

    // SRA / SRL of the MSB by 31
    run_op(2'd2, 32'h8000_0000, 31);
    lit(2, 32'hFFFF_FFFF, 8);
    lit(0, 32'hFFFF_FFFF, 31);
    run_op(2'd1, 32'h8000_0000, 31);
    lit(2, 32'h0000_0001, 8);

    // zero shift and pass-through
    run_op(2'd0, 32'h0000_0001, 0);
    lit(0, 32'h0000_0001, 1);
    lit(3, 32'h0000_0001, 1);
    run_op(2'd3, 32'hDEAD_BEEF, 5);
    lit(0, 32'hDEAD_BEEF, 1);
    lit(2, 32'hDEAD_BEEF, 1);

    // back-pressure on the result, then back-to-back request
    out_ready = 1'b0;
    issue(2'd0, 32'hFFFF_FFFF, 31);
    wait_all_valid();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_result4", dres[4], 32'h8000_0000);
    chk("hold_result0", dres[0], 32'h8000_0000);
    chk("hold_in_ready", 32'(drdy), 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(drdy), 32'h1F);
    issue(2'd1, 32'h0000_0048, 3);
    chk("b2b_valid4", 32'(dval[4]), 32'h1);
    chk("b2b_result4", dres[4], 32'h0000_0009);
    wait_idle();

    // request presented together with flush is dropped
    op = 2'd0; operand = 32'h1234_5678; shamt = 5'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", 32'(drdy), 32'h1F);
    chk("flush_idle_busy", 32'(dbusy), 32'h0);

    // flush in the middle of a long shift
    issue(2'd1, 32'hF0F0_1234, 20);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_ready0", 32'(drdy[0]), 32'h1);
    chk("flush_valid0", 32'(dval[0]), 32'h0);
    wait_idle();
    chk("flush_never_valid0", 32'(lat_seen[0]), 32'h0);
    chk("flush_never_valid1", 32'(lat_seen[1]), 32'h0);

    // asynchronous reset in the middle of a long shift
    issue(2'd2, 32'h8000_1234, 20);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("areset_result0", dres[0], 32'h0);
    chk("areset_ready", 32'(drdy), 32'h1F);
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_idle();
    chk("areset_never_valid0", 32'(lat_seen[0]), 32'h0);
    run_op(2'd1, 32'h0000_0048, 3);
    lit(0, 32'h0000_0009, 3);

    // randomised operations
    for (int t = 0; t < 40; t++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 31)));
    end

    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
